// File: rtl/level_progress_if.sv
// level_progress_if: character/trigger inputs and renderer handshake for level_progress_fsm.
interface level_progress_if #(
  parameter int NUM_STAGES = 4,
  parameter int X_W = 9,
  parameter int Y_W = 8
);
  localparam int SW = $clog2(NUM_STAGES) < 1 ? 1 : $clog2(NUM_STAGES);
  logic activate, spriteDead, doneRedraw;
  logic [X_W-1:0] charX, goalX;
  logic [Y_W-1:0] charY, goalY;
  logic [NUM_STAGES*X_W-1:0] fwdX, backX;
  logic [NUM_STAGES*Y_W-1:0] fwdY, backY;
  logic [SW-1:0] stage, targetStage;
  logic redrawReq, busy, finished;
  logic [7:0] restartCount;
  modport master (
    output activate, spriteDead, doneRedraw, charX, charY, fwdX, fwdY, backX, backY, goalX, goalY,
    input stage, targetStage, redrawReq, busy, finished, restartCount
  );
  modport slave (
    input activate, spriteDead, doneRedraw, charX, charY, fwdX, fwdY, backX, backY, goalX, goalY,
    output stage, targetStage, redrawReq, busy, finished, restartCount
  );
endinterface

// File: rtl/level_progress_fsm.sv
// level_progress_fsm: steps through puzzle stages on trigger+activate, handshaking each redraw with the renderer.
module level_progress_fsm #(
  parameter int NUM_STAGES = 4,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int HIT_TOL = 2
) (
  input logic clock,
  input logic reset,
  level_progress_if.slave bus
);
  localparam int SW = $clog2(NUM_STAGES) < 1 ? 1 : $clog2(NUM_STAGES);
  localparam logic [1:0] S_REQ = 2'd0, S_WAIT = 2'd1, S_PLAY = 2'd2, S_DONE = 2'd3;
  localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);
  localparam logic [X_W:0] TOL_X = (X_W + 1)'(HIT_TOL);
  localparam logic [Y_W:0] TOL_Y = (Y_W + 1)'(HIT_TOL);
  // Distances use one extra bit so targets near 0 or the coordinate max never wrap.
  function automatic logic near_x(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
    logic [X_W:0] d;
    d = a >= b ? {1'b0, a} - {1'b0, b} : {1'b0, b} - {1'b0, a};
    return d <= TOL_X;
  endfunction
  function automatic logic near_y(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
    logic [Y_W:0] d;
    d = a >= b ? {1'b0, a} - {1'b0, b} : {1'b0, b} - {1'b0, a};
    return d <= TOL_Y;
  endfunction
  logic [1:0] state_q, state_d;
  logic [SW-1:0] stage_q, stage_d, target_q, target_d;
  logic [7:0] count_q, count_d;
  logic act_q, act_edge, fwd_hit, back_hit, goal_hit;
  always_comb begin
    act_edge = bus.activate & ~act_q;
    fwd_hit = near_x(bus.charX, bus.fwdX[stage_q*X_W +: X_W]) & near_y(bus.charY, bus.fwdY[stage_q*Y_W +: Y_W]);
    back_hit = near_x(bus.charX, bus.backX[stage_q*X_W +: X_W]) & near_y(bus.charY, bus.backY[stage_q*Y_W +: Y_W]);
    goal_hit = near_x(bus.charX, bus.goalX) & near_y(bus.charY, bus.goalY);
    state_d = state_q;
    stage_d = stage_q;
    target_d = target_q;
    count_d = count_q;
    case (state_q)
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        stage_d = bus.doneRedraw ? target_q : stage_q;
        state_d = bus.doneRedraw ? S_PLAY : S_WAIT;
      end
      S_PLAY:
        if (bus.spriteDead) begin
          target_d = '0;
          count_d = count_q + {7'd0, count_q != 8'hff};
          state_d = S_REQ;
        end else if (stage_q == LAST && goal_hit) begin
          state_d = S_DONE;
        end else if (act_edge && stage_q != LAST && fwd_hit) begin
          target_d = stage_q + SW'(1);
          state_d = S_REQ;
        end else if (act_edge && stage_q != '0 && back_hit) begin
          target_d = stage_q - SW'(1);
          state_d = S_REQ;
        end
      default: ;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_REQ;
      stage_q <= '0;
      target_q <= '0;
      count_q <= '0;
      act_q <= 1'b1;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      target_q <= target_d;
      count_q <= count_d;
      act_q <= bus.activate;
    end
  end
  assign bus.stage = stage_q;
  assign bus.targetStage = target_q;
  assign bus.redrawReq = state_q == S_REQ && !reset;
  assign bus.busy = state_q == S_REQ || state_q == S_WAIT;
  assign bus.finished = state_q == S_DONE;
  assign bus.restartCount = count_q;
endmodule

// File: tb/tb_level_progress_fsm.sv
// tb_level_progress_fsm: vector table plus hand sequences, expected outputs queued per cycle and checked mid-cycle.
module tb_level_progress_fsm;
  localparam int IX = 450, IY = 220;
  typedef struct packed {
    logic [1:0] st, tg;
    logic rq, bz, fn;
    logic [7:0] ct;
  } exp_t;
  typedef struct {
    logic r, a, d, dn;
    logic [8:0] x;
    logic [7:0] y;
    exp_t e;
  } vec_t;
  typedef struct {
    string name;
    exp_t e;
  } sb_t;
  logic clk = 1'b0, rst = 1'b1;
  int n_vec = 0, n_bad = 0;
  sb_t sb[$];
  vec_t tbl[$];
  level_progress_if #(.NUM_STAGES(4), .X_W(9), .Y_W(8)) bus ();
  level_progress_fsm #(.NUM_STAGES(4), .X_W(9), .Y_W(8), .HIT_TOL(2)) dut (
    .clock(clk), .reset(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(logic r, logic a, logic d, logic dn, int x, int y,
                             int st, int tg, logic rq, logic bz, logic fn, int ct);
    vec_t t;
    t.r = r; t.a = a; t.d = d; t.dn = dn;
    t.x = 9'(x); t.y = 8'(y);
    t.e = '{st: 2'(st), tg: 2'(tg), rq: rq, bz: bz, fn: fn, ct: 8'(ct)};
    return t;
  endfunction
  task automatic step(input vec_t t, input string name);
    @(posedge clk);
    #1;
    rst = t.r;
    bus.activate = t.a;
    bus.spriteDead = t.d;
    bus.doneRedraw = t.dn;
    bus.charX = t.x;
    bus.charY = t.y;
    sb.push_back('{name: name, e: t.e});
  endtask
  task automatic climb(input int from, input int x, input int y, input int ct);
    step(v(0, 0, 0, 0, x, y, from, from, 0, 0, 0, ct), "climb_pos");
    step(v(0, 1, 0, 0, x, y, from, from, 0, 0, 0, ct), "climb_press");
    step(v(0, 0, 0, 0, IX, IY, from, from + 1, 1, 1, 0, ct), "climb_req");
    step(v(0, 0, 0, 1, IX, IY, from, from + 1, 0, 1, 0, ct), "climb_wait");
  endtask
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_t s;
      exp_t a;
      s = sb.pop_front();
      a = '{st: bus.stage, tg: bus.targetStage, rq: bus.redrawReq, bz: bus.busy,
            fn: bus.finished, ct: bus.restartCount};
      n_vec++;
      if (a !== s.e) begin
        n_bad++;
        $display("FAIL %s: got st=%0d tg=%0d rq=%0b busy=%0b fin=%0b cnt=%0d, want st=%0d tg=%0d rq=%0b busy=%0b fin=%0b cnt=%0d",
                 s.name, a.st, a.tg, a.rq, a.bz, a.fn, a.ct, s.e.st, s.e.tg, s.e.rq, s.e.bz, s.e.fn, s.e.ct);
      end
    end
  end
  initial begin
    bus.fwdX = {9'd420, 9'd50, 9'd300, 9'd100};
    bus.fwdY = {8'd20, 8'd60, 8'd150, 8'd50};
    bus.backX = {9'd400, 9'd50, 9'd200, 9'd10};
    bus.backY = {8'd200, 8'd60, 8'd100, 8'd10};
    bus.goalX = '0;
    bus.goalY = '0;
    bus.activate = 1'b1;
    bus.spriteDead = 1'b0;
    bus.doneRedraw = 1'b0;
    bus.charX = 9'(IX);
    bus.charY = 8'(IY);
    repeat (2) @(posedge clk);
    tbl.push_back(v(1, 1, 0, 0, IX, IY, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, IX, IY, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(0, 1, 0, 0, IX, IY, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, IX, IY, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 102, 48, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 103, 50, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 103, 50, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 102, 48, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 102, 48, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, IX, IY, 0, 1, 1, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, IX, IY, 0, 1, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, IX, IY, 0, 1, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 200, 100, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 201, 101, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 200, 100, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 200, 100, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, IX, IY, 1, 0, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, IX, IY, 1, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 10, 10, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 10, 10, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, IX, IY, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) step(tbl[i], $sformatf("table_%0d", i));
    climb(0, 100, 50, 0);
    climb(1, 298, 152, 0);
    step(v(0, 0, 1, 0, IX, IY, 2, 2, 0, 0, 0, 0), "death_play");
    step(v(0, 0, 1, 0, IX, IY, 2, 0, 1, 1, 0, 1), "death_req");
    step(v(0, 0, 1, 0, IX, IY, 2, 0, 0, 1, 0, 1), "death_in_wait");
    step(v(0, 0, 1, 1, IX, IY, 2, 0, 0, 1, 0, 1), "death_ack");
    step(v(0, 0, 0, 0, IX, IY, 0, 0, 0, 0, 0, 1), "death_restart");
    climb(0, 100, 50, 1);
    climb(1, 300, 150, 1);
    climb(2, 51, 61, 1);
    step(v(0, 0, 0, 0, 420, 20, 3, 3, 0, 0, 0, 1), "last_fwd_pos");
    step(v(0, 1, 0, 0, 420, 20, 3, 3, 0, 0, 0, 1), "last_fwd_press");
    step(v(0, 0, 0, 0, 1, 2, 3, 3, 0, 0, 0, 1), "goal_enter");
    step(v(0, 1, 1, 1, 1, 2, 3, 3, 0, 0, 1, 1), "done_ignore1");
    step(v(0, 0, 1, 0, IX, IY, 3, 3, 0, 0, 1, 1), "done_ignore2");
    step(v(0, 1, 0, 1, IX, IY, 3, 3, 0, 0, 1, 1), "done_ignore3");
    step(v(1, 0, 0, 0, IX, IY, 3, 3, 0, 0, 1, 1), "done_reset");
    step(v(0, 0, 0, 0, IX, IY, 0, 0, 1, 1, 0, 0), "done_reset_req");
    step(v(0, 0, 0, 1, IX, IY, 0, 0, 0, 1, 0, 0), "done_reset_wait");
    step(v(0, 0, 0, 0, 100, 50, 0, 0, 0, 0, 0, 0), "rw_pos");
    step(v(0, 1, 0, 0, 100, 50, 0, 0, 0, 0, 0, 0), "rw_press");
    step(v(0, 0, 0, 0, IX, IY, 0, 1, 1, 1, 0, 0), "rw_req");
    step(v(1, 0, 0, 1, IX, IY, 0, 1, 0, 1, 0, 0), "rw_reset_ack");
    step(v(0, 0, 0, 1, IX, IY, 0, 0, 1, 1, 0, 0), "rw_fresh_req");
    step(v(0, 0, 0, 0, IX, IY, 0, 0, 0, 1, 0, 0), "rw_wait");
    step(v(0, 0, 0, 1, IX, IY, 0, 0, 0, 1, 0, 0), "rw_ack");
    for (int i = 0; i < 300; i++) begin
      step(v(0, 0, 1, 0, IX, IY, 0, 0, 0, 0, 0, i < 255 ? i : 255), "sat_dead");
      step(v(0, 0, 0, 0, IX, IY, 0, 0, 1, 1, 0, i + 1 < 255 ? i + 1 : 255), "sat_req");
      step(v(0, 0, 0, 1, IX, IY, 0, 0, 0, 1, 0, i + 1 < 255 ? i + 1 : 255), "sat_wait");
    end
    step(v(0, 0, 0, 0, IX, IY, 0, 0, 0, 0, 0, 255), "sat_final");
    @(negedge clk);
    #1;
    if (bus.restartCount !== 8'd255 || bus.busy !== 1'b0 || bus.redrawReq !== 1'b0 ||
        bus.stage !== 2'd0 || bus.targetStage !== 2'd0 || bus.finished !== 1'b0) begin
      n_bad++;
      $display("FAIL final_state: st=%0d tg=%0d rq=%0b busy=%0b fin=%0b cnt=%0d",
               bus.stage, bus.targetStage, bus.redrawReq, bus.busy, bus.finished, bus.restartCount);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
